bram_fifo_reader: RTL and testbench
===================================

Name: bram_fifo_reader

Overview:
- Synchronous BRAM-backed FIFO for DSP streaming chains. Decouples a free-running sample producer from a consumer that can stall.
- The write side is push-only. The read side drains through a valid/ready handshake with first-word-fall-through.
- Hides the 1- or 2-cycle BRAM read latency behind a small prefetch buffer, so the consumer sees registered output.
- Complements the fixed-delay BRAM line: here the read pointer is consumer-controlled, not a fixed offset from the write pointer.

Parameters:
- WIDTH, 32, data width in bits (<37 for 18Kb BRAM, <73 for 36Kb).
- DEPTH, 1024, FIFO capacity in words; power of two, at least 512.
- LATENCY, 2, BRAM read latency in clocks; 1 or 2 (2 = output register enabled).
- ADDR_BITS, log2(DEPTH), derived localparam; not overridable.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable; when low, all state is frozen.
- din  in  WIDTH  write data.
- din_valid  in  1  push request.
- din_ready  out  1  not full; a push is accepted when din_valid & din_ready & ce.
- dout  out  WIDTH  head-of-queue data, registered.
- dout_valid  out  1  dout holds a valid word.
- dout_ready  in  1  consumer accepts; a pop occurs when dout_valid & dout_ready & ce.
- count  out  ADDR_BITS+1  total words held, including words in flight and in the prefetch buffer.

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - wr_ptr = rd_ptr = 0, count = 0.
  - dout_valid = 0, dout = 0, din_ready = 1.
  - In-flight read pipeline is cleared.
- Storage: BRAM array of DEPTH x WIDTH plus a prefetch buffer of LATENCY+1 entries.
- Total capacity is DEPTH words. din_ready = (count < DEPTH), registered.
- Write: an accepted push writes din to mem[wr_ptr], then wr_ptr++ (mod DEPTH, natural wrap).
- Read pipeline:
  - A BRAM read issues when BRAM holds unread words AND the prefetch buffer has space for every in-flight read plus one.
  - Each issue increments rd_ptr.
  - Data lands in the prefetch buffer exactly LATENCY cycles after issue, tracked by a LATENCY-deep valid shift register.
- Output: dout/dout_valid are the prefetch head.
  - A pop advances the head. The next word presents the following cycle if already buffered.
  - dout is stable while dout_valid & !dout_ready.
- Latency: an empty-FIFO push at cycle t gives dout_valid = 1 at cycle t+LATENCY+2.
- Throughput: with dout_ready held high and no starvation, one word per cycle.
- Simultaneous push and pop when full: the push is refused because din_ready was 0 that cycle. The pop frees a slot, so din_ready = 1 the next cycle.
- Simultaneous push and pop otherwise: count is unchanged.
- Same-address hazard: a read never issues for the address being written that cycle. rd_ptr only reads words committed at least one cycle earlier, so no read-during-write collision occurs.
- Push while full: ignored, no state change (see optional feature).
- Pop while empty: cannot occur because dout_valid = 0.
- ce low: pointers, count, pipeline and outputs hold. BRAM enables are gated by ce.
- Reset mid-operation: contents are discarded, outputs return to reset values immediately, and BRAM contents are not cleared.

Optional Feature:
- BRAM_FIFO_OVF_FLAG_EN.
- When defined: adds output ovf (1 bit), sticky, reset 0. It sets the cycle after any din_valid & !din_ready & ce, and clears only on reset.
- When undefined: the ovf port is absent, and overflow pushes are silently dropped.

Decomposition:
- Shared package: log2/ceil-log2 function, LATENCY_MIN = 1 and LATENCY_MAX = 2, and a common FIFO count type width rule (ADDR_BITS+1).
- One sub-module: bram_sdp_ram.
  - Inferred simple-dual-port RAM: write port (we, waddr, wdata); read port (re, raddr, rdata); optional output register selected by LATENCY.
  - Reusable by the existing delay-line block.

Test Plan:
1. Reset then single push of 0xA5A5_0001 with dout_ready = 1 -> dout_valid rises at cycle 4 (LATENCY = 2) with dout = 0xA5A5_0001, then falls; count returns 0.
2. Push 1024 sequential words with dout_ready = 0 -> din_ready falls after word 1024 and count = 1024. Word 1025 is ignored (ovf = 1 if enabled). Then drain -> exactly 0..1023 in order, with no gaps.
3. Continuous push and pop at one word per cycle for 5000 cycles (pointer wrap ~5x) -> output sequence equals input, and count stays constant after fill.
4. Random dout_ready (50%) with random din_valid -> scoreboard matches, dout stable during stalls, no loss or duplication; repeat with LATENCY = 1.
5. Toggle ce low for 10 cycles mid-stream -> no pointer or count movement, and identical output resumes.
6. Assert rst_n low with 300 words queued -> dout_valid = 0, count = 0 and din_ready = 1 immediately. A subsequent push of 0x1234 emerges first.

Source files
------------

// File: rtl/bram_fifo_reader_pkg.sv
// Shared constants and elaboration helpers for the BRAM-backed streaming FIFO
// and the simple-dual-port RAM it is built on.
package bram_fifo_reader_pkg;

  localparam int LATENCY_MIN = 32'sd1;
  localparam int LATENCY_MAX = 32'sd2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem >>> 1;
    end
    return result;
  endfunction

  // A count must represent 0..DEPTH inclusive, hence one bit above the address.
  function automatic int count_width(input int addr_bits);
    return addr_bits + 32'sd1;
  endfunction

endpackage

// File: rtl/bram_sdp_ram.sv
// Inferred simple-dual-port block RAM with an optional output register
// (LATENCY = 2). Also used by the fixed-delay BRAM line.
module bram_sdp_ram
  import bram_fifo_reader_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  localparam int ADDR_BITS = clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 ce,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_r;

  // Write port; contents deliberately have no reset so the array maps onto BRAM.
  always_ff @(posedge clk) begin
    if (ce && we) begin
      mem[waddr] <= wdata;
    end
  end

  // Synchronous read port.
  always_ff @(posedge clk) begin
    if (ce && re) begin
      rd_r <= mem[raddr];
    end
  end

  generate
    if (LATENCY >= LATENCY_MAX) begin : g_oreg
      logic [WIDTH-1:0] oreg_r;
      // Output register advances only with ce so it stays aligned with the caller's pipeline.
      always_ff @(posedge clk) begin
        if (ce) begin
          oreg_r <= rd_r;
        end
      end
      assign rdata = oreg_r;
    end else begin : g_noreg
      assign rdata = rd_r;
    end
  endgenerate

endmodule

// File: rtl/bram_fifo_reader.sv
// BRAM-backed first-word-fall-through FIFO with a valid/ready read side.
// Optional sticky overflow flag output under `BRAM_FIFO_OVF_FLAG_EN.
module bram_fifo_reader
  import bram_fifo_reader_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  localparam int ADDR_BITS = clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [ADDR_BITS:0] count
`ifdef BRAM_FIFO_OVF_FLAG_EN
  ,
  output logic               ovf
`endif
);

  localparam int CNT_W    = count_width(ADDR_BITS);
  localparam int PTR_W    = ADDR_BITS + 32'sd1;
  localparam int PF_DEPTH = LATENCY + 32'sd1;
  localparam int PF_CNT_W = clog2(PF_DEPTH + 32'sd1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // Pointers carry an extra wrap bit so "BRAM holds unread words" is a plain compare.
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    count_r, count_s;
  logic                din_ready_r, dout_valid_r;
  logic [WIDTH-1:0]    pf_r [PF_DEPTH];
  logic [WIDTH-1:0]    pf_s [PF_DEPTH];
  logic [PF_CNT_W-1:0] pf_cnt_r, pf_cnt_s;
  logic [LATENCY-1:0]  inflight_r, inflight_s;
  logic                push_s, pop_s, issue_s, land_s;
  logic [WIDTH-1:0]    rdata_s;
  int                  occupancy_s;

  // Handshakes and read-issue credit; a pop this cycle frees a slot so the
  // pipeline sustains one word per clock.
  always_comb begin
    push_s      = din_valid & din_ready_r & ce;
    pop_s       = dout_valid_r & dout_ready & ce;
    land_s      = ce & inflight_r[LATENCY-1];
    occupancy_s = int'(pf_cnt_r) - int'(pop_s);
    for (int i = 0; i < LATENCY; i++) begin
      occupancy_s = occupancy_s + int'(inflight_r[i]);
    end
    issue_s    = ce & (wr_ptr_r != rd_ptr_r) & (occupancy_s < PF_DEPTH);
    inflight_s = (inflight_r << 1'b1) | LATENCY'(issue_s);
  end

  // Total occupancy, including words still inside the read pipeline.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + CNT_W'(1);
      2'b01:   count_s = count_r - CNT_W'(1);
      default: count_s = count_r;
    endcase
  end

  // Prefetch buffer is a shift queue: entry 0 is the registered head seen on dout.
  always_comb begin
    pf_s     = pf_r;
    pf_cnt_s = pf_cnt_r;
    if (pop_s) begin
      for (int i = 0; i < PF_DEPTH - 1; i++) begin
        pf_s[i] = pf_r[i + 1];
      end
      pf_cnt_s = pf_cnt_r - PF_CNT_W'(1);
    end else begin
      pf_cnt_s = pf_cnt_r;
    end
    if (land_s) begin
      for (int i = 0; i < PF_DEPTH; i++) begin
        pf_s[i] = (PF_CNT_W'(i) == pf_cnt_s) ? rdata_s : pf_s[i];
      end
      pf_cnt_s = pf_cnt_s + PF_CNT_W'(1);
    end else begin
      pf_cnt_s = pf_cnt_s;
    end
  end

  // Pointer, count, pipeline and output state; everything freezes while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      din_ready_r  <= 1'b1;
      dout_valid_r <= 1'b0;
      pf_cnt_r     <= '0;
      inflight_r   <= '0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        pf_r[i] <= '0;
      end
    end else if (ce) begin
      wr_ptr_r     <= wr_ptr_r + PTR_W'(push_s);
      rd_ptr_r     <= rd_ptr_r + PTR_W'(issue_s);
      count_r      <= count_s;
      din_ready_r  <= (count_s < FULL_CNT);
      dout_valid_r <= (pf_cnt_s != '0);
      pf_cnt_r     <= pf_cnt_s;
      inflight_r   <= inflight_s;
      pf_r         <= pf_s;
    end
  end

`ifdef BRAM_FIFO_OVF_FLAG_EN
  logic ovf_r;
  // Sticky overflow: a refused push sets it, only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (din_valid && !din_ready_r && ce) begin
      ovf_r <= 1'b1;
    end
  end
  assign ovf = ovf_r;
`endif

  bram_sdp_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) u_ram (
    .clk  (clk),
    .ce   (ce),
    .we   (push_s),
    .waddr(wr_ptr_r[ADDR_BITS-1:0]),
    .wdata(din),
    .re   (issue_s),
    .raddr(rd_ptr_r[ADDR_BITS-1:0]),
    .rdata(rdata_s)
  );

  assign din_ready  = din_ready_r;
  assign dout       = pf_r[0];
  assign dout_valid = dout_valid_r;
  assign count      = count_r;

endmodule

// File: tb/tb_bram_fifo_reader.sv
// Self-checking bench for bram_fifo_reader: LATENCY=2 instance (timing table)
// plus a LATENCY=1 instance sharing stimulus, both scoreboarded.
module tb_bram_fifo_reader;

  logic        clk = 1'b0;
  logic        rst_n, ce, din_valid, dout_ready;
  logic [31:0] din;
  logic [31:0] dout0, dout1;
  logic        dv0, dv1, dr0, dr1;
  logic [10:0] cnt0, cnt1;
`ifdef BRAM_FIFO_OVF_FLAG_EN
  logic        ovf0, ovf1;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic        stall0, stall1;
  logic [31:0] held0, held1;

  typedef struct {
    logic        vld;
    logic [31:0] data;
    logic        rdy;
    logic        en;
    logic        e_valid;
    logic [31:0] e_dout;
    logic [10:0] e_count;
    logic        e_ready;
  } vec_t;
  vec_t tbl [18];

  always #5 clk = ~clk;

  bram_fifo_reader #(.WIDTH(32), .DEPTH(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .din_valid(din_valid),
    .din_ready(dr0), .dout(dout0), .dout_valid(dv0), .dout_ready(dout_ready),
    .count(cnt0)
`ifdef BRAM_FIFO_OVF_FLAG_EN
    , .ovf(ovf0)
`endif
  );

  bram_fifo_reader #(.WIDTH(32), .DEPTH(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .din(din), .din_valid(din_valid),
    .din_ready(dr1), .dout(dout1), .dout_valid(dv1), .dout_ready(dout_ready),
    .count(cnt1)
`ifdef BRAM_FIFO_OVF_FLAG_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard step for one instance, evaluated between clock edges.
  task automatic mon_step(input string tag, input logic dvld, input logic [31:0] dd,
                          input logic dinr, inout logic stall, inout logic [31:0] held,
                          ref logic [31:0] q[$]);
    logic [31:0] exp;
    if (din_valid && dinr) q.push_back(din);
    if (stall) check({tag, "_stall_stable"}, {31'd0, dvld, dd}, {31'd0, 1'b1, held});
    if (dvld && dout_ready) begin
      if (q.size() == 0) begin
        check({tag, "_pop_unexpected"}, 64'd1, 64'd0);
      end else begin
        exp = q.pop_front();
        check({tag, "_data"}, 64'(dd), 64'(exp));
      end
    end
    stall = dvld && !dout_ready;
    held  = dd;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall0 = 1'b0;
      stall1 = 1'b0;
    end else if (ce) begin
      mon_step("l2", dv0, dout0, dr0, stall0, held0, q0);
      mon_step("l1", dv1, dout1, dr1, stall1, held1, q1);
    end
  end

  task automatic drain(input string name);
    int guard;
    guard      = 0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    ce         = 1'b1;
    while ((cnt0 != 11'd0 || cnt1 != 11'd0) && guard < 3000) begin
      tick();
      guard++;
    end
    check({name, "_drain_timeout"}, 64'(guard >= 3000), 64'd0);
    check({name, "_q0_empty"}, 64'(q0.size()), 64'd0);
    check({name, "_q1_empty"}, 64'(q1.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard, pops, gaps, bad, seq;
    logic acc, s_dv, s_dr;
    logic [31:0] s_d;
    logic [10:0] s_cnt;

    rst_n = 1'b0; ce = 1'b1; din_valid = 1'b0; din = 32'd0; dout_ready = 1'b0;

    // Cycle-by-cycle LATENCY=2 expectations: row k drives cycle k, checks state of cycle k+1.
    tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 32'h0, 11'd1, 1'b1};
    tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 11'd1, 1'b1};
    tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 11'd1, 1'b1};
    tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 11'd1, 1'b1};
    tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 11'd0, 1'b1};
    tbl[5]  = '{1'b1, 32'h11,        1'b0, 1'b1, 1'b0, 32'h0, 11'd1, 1'b1};
    tbl[6]  = '{1'b1, 32'h22,        1'b0, 1'b1, 1'b0, 32'h0, 11'd2, 1'b1};
    tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'h0, 11'd2, 1'b1};
    tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h11, 11'd2, 1'b1};
    tbl[9]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 32'h11, 11'd2, 1'b1};
    tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h22, 11'd1, 1'b1};
    tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 11'd0, 1'b1};
    tbl[12] = '{1'b1, 32'h33,        1'b1, 1'b0, 1'b0, 32'h0, 11'd0, 1'b1};
    tbl[13] = '{1'b1, 32'h33,        1'b1, 1'b1, 1'b0, 32'h0, 11'd1, 1'b1};
    tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 11'd1, 1'b1};
    tbl[15] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 11'd1, 1'b1};
    tbl[16] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 32'h33, 11'd1, 1'b1};
    tbl[17] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0, 11'd0, 1'b1};

    repeat (3) tick();
    check("rst_dout_valid", 64'(dv0), 64'd0);
    check("rst_dout", 64'(dout0), 64'd0);
    check("rst_count", 64'(cnt0), 64'd0);
    check("rst_din_ready", 64'(dr0), 64'd1);
`ifdef BRAM_FIFO_OVF_FLAG_EN
    check("rst_ovf", 64'(ovf0), 64'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      din_valid = tbl[i].vld; din = tbl[i].data; dout_ready = tbl[i].rdy; ce = tbl[i].en;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(dv0), 64'(tbl[i].e_valid));
      check($sformatf("vec%0d_count", i), 64'(cnt0), 64'(tbl[i].e_count));
      check($sformatf("vec%0d_din_ready", i), 64'(dr0), 64'(tbl[i].e_ready));
      if (tbl[i].e_valid) check($sformatf("vec%0d_dout", i), 64'(dout0), 64'(tbl[i].e_dout));
    end
    drain("t1");

    // Fill to capacity with the consumer stalled, then overflow by one.
    dout_ready = 1'b0; din_valid = 1'b1; sent = 0; guard = 0;
    while (sent < 1024 && guard < 3000) begin
      din = 32'(sent);
      acc = dr0;
      if (sent == 1023) check("fill_ready_before_last", 64'(dr0), 64'd1);
      tick();
      if (acc) sent++;
      guard++;
    end
    check("fill_count_l2", 64'(cnt0), 64'd1024);
    check("fill_count_l1", 64'(cnt1), 64'd1024);
    check("fill_din_ready_l2", 64'(dr0), 64'd0);
    check("fill_din_ready_l1", 64'(dr1), 64'd0);
    din = 32'hDEAD_BEEF;
    tick();
    din_valid = 1'b0;
    check("ovf_push_count", 64'(cnt0), 64'd1024);
    check("ovf_push_din_ready", 64'(dr0), 64'd0);
`ifdef BRAM_FIFO_OVF_FLAG_EN
    check("ovf_flag_set", 64'(ovf0), 64'd1);
`endif
    dout_ready = 1'b1; pops = 0; gaps = 0; guard = 0;
    while ((cnt0 != 11'd0 || cnt1 != 11'd0) && guard < 3000) begin
      if (dv0) pops++;
      else if (cnt0 != 11'd0) gaps++;
      tick();
      guard++;
    end
    check("drain_pops", 64'(pops), 64'd1024);
    check("drain_gaps", 64'(gaps), 64'd0);
    drain("t2");

    // Full-rate streaming across several pointer wraps.
    din_valid = 1'b1; dout_ready = 1'b1; bad = 0; seq = 0;
    for (int c = 0; c < 5000; c++) begin
      din = 32'h1000_0000 + 32'(seq); seq++;
      tick();
      if (c >= 8 && (cnt0 != 11'd4 || cnt1 != 11'd3)) bad++;
    end
    check("stream_steady_count", 64'(bad), 64'd0);

    // Clock-enable freeze mid-stream.
    s_cnt = cnt0; s_dv = dv0; s_d = dout0; s_dr = dr0;
    ce = 1'b0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      din = 32'h1000_0000 + 32'(seq); seq++;
      tick();
      if (cnt0 != s_cnt || dv0 != s_dv || dout0 != s_d || dr0 != s_dr || cnt1 != 11'd3) bad++;
    end
    check("ce_freeze", 64'(bad), 64'd0);
    ce = 1'b1; bad = 0;
    for (int c = 0; c < 20; c++) begin
      din = 32'h1000_0000 + 32'(seq); seq++;
      tick();
      if (cnt0 != 11'd4 || cnt1 != 11'd3) bad++;
    end
    check("ce_resume_count", 64'(bad), 64'd0);
    drain("t3");

    // Random producer and consumer.
    bad = 0;
    for (int c = 0; c < 2000; c++) begin
      din_valid  = 1'($urandom_range(0, 1));
      din        = $urandom;
      dout_ready = 1'($urandom_range(0, 1));
      tick();
      if (32'(cnt0) != q0.size() || 32'(cnt1) != q1.size()) bad++;
    end
    check("random_count_tracks", 64'(bad), 64'd0);
    drain("t4");

    // Reset with 300 words queued.
    dout_ready = 1'b0; din_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      din = 32'h3000_0000 + 32'(i);
      tick();
    end
    din_valid = 1'b0;
    check("pre_rst_count", 64'(cnt0), 64'd300);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout_valid_l2", 64'(dv0), 64'd0);
    check("mid_rst_count_l2", 64'(cnt0), 64'd0);
    check("mid_rst_din_ready_l2", 64'(dr0), 64'd1);
    check("mid_rst_dout_valid_l1", 64'(dv1), 64'd0);
    check("mid_rst_count_l1", 64'(cnt1), 64'd0);
    q0.delete();
    q1.delete();
    tick();
    rst_n = 1'b1;
`ifdef BRAM_FIFO_OVF_FLAG_EN
    check("mid_rst_ovf", 64'(ovf0), 64'd0);
`endif
    din = 32'h0000_1234; din_valid = 1'b1; dout_ready = 1'b1;
    tick();
    din_valid = 1'b0; guard = 0;
    while (!dv0 && guard < 20) begin
      tick();
      guard++;
    end
    check("post_rst_valid", 64'(dv0), 64'd1);
    check("post_rst_first_word", 64'(dout0), 64'h1234);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
